// File: rtl/ysyx_23060203_read_arb.sv
// Two-master AXI4 read arbiter: IFU and LSU share one downstream read port.
// Only one transaction is outstanding at a time. Simultaneous requests
// alternate between the masters, and each master has a saturating count of
// the address handshakes it has completed.
module ysyx_23060203_read_arb #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  // IFU slave port
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [31:0]       ifu_araddr,
  input  logic [3:0]        ifu_arid,
  input  logic [7:0]        ifu_arlen,
  input  logic [2:0]        ifu_arsize,
  input  logic [1:0]        ifu_arburst,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  output logic [3:0]        ifu_rid,
  // LSU slave port
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [31:0]       lsu_araddr,
  input  logic [3:0]        lsu_arid,
  input  logic [7:0]        lsu_arlen,
  input  logic [2:0]        lsu_arsize,
  input  logic [1:0]        lsu_arburst,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rlast,
  output logic [3:0]        lsu_rid,
  // downstream master port
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [31:0]       mem_araddr,
  output logic [3:0]        mem_arid,
  output logic [7:0]        mem_arlen,
  output logic [2:0]        mem_arsize,
  output logic [1:0]        mem_arburst,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rlast,
  input  logic [3:0]        mem_rid,
  // grant statistics
  output logic [CNT_W-1:0]  ifu_grants,
  output logic [CNT_W-1:0]  lsu_grants
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    AR_IFU = 5'b00010,
    AR_LSU = 5'b00100,
    R_IFU  = 5'b01000,
    R_LSU  = 5'b10000
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;
  // Low means IFU won the most recent grant, high means LSU did.
  logic   last_lsu;

  // Grant counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // State, round-robin memory and grant counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_lsu   <= 1'b0;
      ifu_grants <= '0;
      lsu_grants <= '0;
    end else begin
      state <= state_nxt;
      if (state == AR_IFU && ifu_arvalid && mem_arready) begin
        last_lsu   <= 1'b0;
        ifu_grants <= sat_inc(ifu_grants);
      end
      if (state == AR_LSU && lsu_arvalid && mem_arready) begin
        last_lsu   <= 1'b1;
        lsu_grants <= sat_inc(lsu_grants);
      end
    end
  end

  // Channel steering and next-state selection; everything idles at zero.
  always_comb begin
    state_nxt   = state;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    mem_arvalid = 1'b0;
    mem_araddr  = '0;
    mem_arid    = '0;
    mem_arlen   = '0;
    mem_arsize  = '0;
    mem_arburst = '0;
    mem_rready  = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rlast   = 1'b0;
    ifu_rid     = '0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rlast   = 1'b0;
    lsu_rid     = '0;
    case (state)
      IDLE: begin
        if (ifu_arvalid && lsu_arvalid) begin
          state_nxt = last_lsu ? AR_IFU : AR_LSU;
        end else if (ifu_arvalid) begin
          state_nxt = AR_IFU;
        end else if (lsu_arvalid) begin
          state_nxt = AR_LSU;
        end
      end
      AR_IFU: begin
        mem_arvalid = ifu_arvalid;
        mem_araddr  = ifu_araddr;
        mem_arid    = ifu_arid;
        mem_arlen   = ifu_arlen;
        mem_arsize  = ifu_arsize;
        mem_arburst = ifu_arburst;
        ifu_arready = mem_arready;
        if (ifu_arvalid && mem_arready) state_nxt = R_IFU;
      end
      AR_LSU: begin
        mem_arvalid = lsu_arvalid;
        mem_araddr  = lsu_araddr;
        mem_arid    = lsu_arid;
        mem_arlen   = lsu_arlen;
        mem_arsize  = lsu_arsize;
        mem_arburst = lsu_arburst;
        lsu_arready = mem_arready;
        if (lsu_arvalid && mem_arready) state_nxt = R_LSU;
      end
      R_IFU: begin
        ifu_rvalid = mem_rvalid;
        ifu_rdata  = mem_rdata;
        ifu_rresp  = mem_rresp;
        ifu_rlast  = mem_rlast;
        ifu_rid    = mem_rid;
        mem_rready = ifu_rready;
        if (mem_rvalid && ifu_rready && mem_rlast) state_nxt = IDLE;
      end
      R_LSU: begin
        lsu_rvalid = mem_rvalid;
        lsu_rdata  = mem_rdata;
        lsu_rresp  = mem_rresp;
        lsu_rlast  = mem_rlast;
        lsu_rid    = mem_rid;
        mem_rready = lsu_rready;
        if (mem_rvalid && lsu_rready && mem_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060203_read_arb.sv
// Bench for the two-master read arbiter: directed scenarios followed by
// random traffic, all checked every cycle against a transaction-level model.
module tb_ysyx_23060203_read_arb;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic              ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
  logic [31:0]       ifu_araddr;
  logic [3:0]        ifu_arid, ifu_rid;
  logic [7:0]        ifu_arlen;
  logic [2:0]        ifu_arsize;
  logic [1:0]        ifu_arburst, ifu_rresp;
  logic [DATA_W-1:0] ifu_rdata;
  logic              lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
  logic [31:0]       lsu_araddr;
  logic [3:0]        lsu_arid, lsu_rid;
  logic [7:0]        lsu_arlen;
  logic [2:0]        lsu_arsize;
  logic [1:0]        lsu_arburst, lsu_rresp;
  logic [DATA_W-1:0] lsu_rdata;
  logic              mem_arvalid, mem_arready, mem_rvalid, mem_rready, mem_rlast;
  logic [31:0]       mem_araddr;
  logic [3:0]        mem_arid, mem_rid;
  logic [7:0]        mem_arlen;
  logic [2:0]        mem_arsize;
  logic [1:0]        mem_arburst, mem_rresp;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  ifu_grants, lsu_grants;

  ysyx_23060203_read_arb #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
    .ifu_arburst(ifu_arburst), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize),
    .lsu_arburst(lsu_arburst), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arid(mem_arid), .mem_arlen(mem_arlen), .mem_arsize(mem_arsize),
    .mem_arburst(mem_arburst), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rlast(mem_rlast), .mem_rid(mem_rid),
    .ifu_grants(ifu_grants), .lsu_grants(lsu_grants)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the port (0 none, 1 IFU, 2 LSU), whether the
  // owner is still in its address phase, who won last, raw grant totals and
  // how many beats the slave still owes.
  int owner, last_win, n_ifu, n_lsu, beats_left;
  bit in_addr, drop_ifu, drop_lsu;

  logic              e_mem_arvalid, e_ifu_arready, e_lsu_arready, e_mem_rready;
  logic [31:0]       e_araddr;
  logic [7:0]        e_arlen;
  logic [3:0]        e_arid;
  logic              e_ifu_rvalid, e_lsu_rvalid, e_ifu_rlast, e_lsu_rlast;
  logic [DATA_W-1:0] e_ifu_rdata, e_lsu_rdata;
  logic [1:0]        e_ifu_rresp, e_lsu_rresp;
  logic [3:0]        e_ifu_rid, e_lsu_rid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat(input int n);
    if (n >= (1 << CNT_W) - 1) return CNT_MAX;
    return n[CNT_W-1:0];
  endfunction

  function automatic void model_reset();
    owner = 0; in_addr = 0; last_win = 1; n_ifu = 0; n_lsu = 0; beats_left = 0;
    drop_ifu = 0; drop_lsu = 0;
  endfunction

  function automatic void compute_exp();
    bit ai, al, ri, rl;
    ai = in_addr && owner == 1;
    al = in_addr && owner == 2;
    ri = !in_addr && owner == 1;
    rl = !in_addr && owner == 2;
    e_mem_arvalid = ai ? ifu_arvalid : (al ? lsu_arvalid : 1'b0);
    e_araddr      = ai ? ifu_araddr : (al ? lsu_araddr : 32'h0);
    e_arlen       = ai ? ifu_arlen : (al ? lsu_arlen : 8'h0);
    e_arid        = ai ? ifu_arid : (al ? lsu_arid : 4'h0);
    e_ifu_arready = ai ? mem_arready : 1'b0;
    e_lsu_arready = al ? mem_arready : 1'b0;
    e_mem_rready  = ri ? ifu_rready : (rl ? lsu_rready : 1'b0);
    e_ifu_rvalid  = ri ? mem_rvalid : 1'b0;
    e_ifu_rdata   = ri ? mem_rdata : '0;
    e_ifu_rresp   = ri ? mem_rresp : 2'b0;
    e_ifu_rlast   = ri ? mem_rlast : 1'b0;
    e_ifu_rid     = ri ? mem_rid : 4'h0;
    e_lsu_rvalid  = rl ? mem_rvalid : 1'b0;
    e_lsu_rdata   = rl ? mem_rdata : '0;
    e_lsu_rresp   = rl ? mem_rresp : 2'b0;
    e_lsu_rlast   = rl ? mem_rlast : 1'b0;
    e_lsu_rid     = rl ? mem_rid : 4'h0;
  endfunction

  task automatic check_all();
    chk("mem_arvalid", mem_arvalid, e_mem_arvalid);
    chk("mem_araddr", mem_araddr, e_araddr);
    chk("mem_arlen", mem_arlen, e_arlen);
    chk("mem_arid", mem_arid, e_arid);
    chk("ifu_arready", ifu_arready, e_ifu_arready);
    chk("lsu_arready", lsu_arready, e_lsu_arready);
    chk("mem_rready", mem_rready, e_mem_rready);
    chk("ifu_rvalid", ifu_rvalid, e_ifu_rvalid);
    chk("ifu_rdata", ifu_rdata, e_ifu_rdata);
    chk("ifu_rresp", ifu_rresp, e_ifu_rresp);
    chk("ifu_rlast", ifu_rlast, e_ifu_rlast);
    chk("ifu_rid", ifu_rid, e_ifu_rid);
    chk("lsu_rvalid", lsu_rvalid, e_lsu_rvalid);
    chk("lsu_rdata", lsu_rdata, e_lsu_rdata);
    chk("lsu_rresp", lsu_rresp, e_lsu_rresp);
    chk("lsu_rlast", lsu_rlast, e_lsu_rlast);
    chk("lsu_rid", lsu_rid, e_lsu_rid);
    chk("ifu_grants", ifu_grants, sat(n_ifu));
    chk("lsu_grants", lsu_grants, sat(n_lsu));
  endtask

  // Advance the model across one rising edge using the inputs it saw.
  function automatic void model_update();
    if (!reset) begin
      model_reset();
      return;
    end
    if (owner == 0) begin
      if (ifu_arvalid && lsu_arvalid) owner = (last_win == 1) ? 2 : 1;
      else if (ifu_arvalid) owner = 1;
      else if (lsu_arvalid) owner = 2;
      in_addr = (owner != 0);
    end else if (in_addr) begin
      if (e_mem_arvalid && mem_arready) begin
        in_addr    = 0;
        last_win   = owner;
        beats_left = int'(e_arlen) + 1;
        if (owner == 1) begin n_ifu++; drop_ifu = 1; end
        else begin n_lsu++; drop_lsu = 1; end
      end
    end else if (mem_rvalid && e_mem_rready) begin
      beats_left--;
      if (mem_rlast) owner = 0;
    end
  endfunction

  // The downstream slave marks the final beat of the burst it accepted.
  function automatic void set_rlast();
    mem_rlast = (owner != 0 && !in_addr && beats_left == 1);
  endfunction

  task automatic tick();
    set_rlast();
    @(negedge clock);
    compute_exp();
    check_all();
    @(posedge clock);
    model_update();
    #1;
    if (drop_ifu) ifu_arvalid = 1'b0;
    if (drop_lsu) lsu_arvalid = 1'b0;
    drop_ifu = 0;
    drop_lsu = 0;
  endtask

  initial begin
    int beats;
    ifu_arvalid = 0; ifu_araddr = 0; ifu_arid = 0; ifu_arlen = 0; ifu_arsize = 3'd2;
    ifu_arburst = 2'b01; ifu_rready = 1;
    lsu_arvalid = 0; lsu_araddr = 0; lsu_arid = 0; lsu_arlen = 0; lsu_arsize = 3'd2;
    lsu_arburst = 2'b01; lsu_rready = 1;
    mem_arready = 0; mem_rvalid = 0; mem_rdata = 0; mem_rresp = 0; mem_rlast = 0; mem_rid = 0;
    model_reset();
    #1 reset = 1'b0;
    #1;
    chk("rst_mem_arvalid", mem_arvalid, 0);
    chk("rst_ifu_arready", ifu_arready, 0);
    chk("rst_ifu_grants", ifu_grants, 0);
    chk("rst_lsu_grants", lsu_grants, 0);
    tick(); tick();
    reset = 1'b1;

    // IFU alone, single beat
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_arlen = 0; ifu_arid = 4'h3;
    mem_arready = 1;
    tick();
    chk("single_arvalid", mem_arvalid, 1);
    chk("single_araddr", mem_araddr, 32'h8000_0000);
    tick();
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; mem_rid = 4'h3;
    set_rlast();
    #1;
    chk("single_rdata", ifu_rdata, 32'hDEAD_BEEF);
    chk("single_rlast", ifu_rlast, 1);
    tick();
    chk("single_grants", ifu_grants, 1);
    chk("single_idle", mem_rready, 0);

    // simultaneous requests alternate, LSU first
    ifu_arvalid = 1; ifu_araddr = 32'h1000;
    lsu_arvalid = 1; lsu_araddr = 32'h2000; lsu_arlen = 0;
    tick();
    chk("tie1_addr", mem_araddr, 32'h2000);
    chk("tie1_ifu_arready", ifu_arready, 0);
    tick(); tick(); tick();
    chk("tie1_next_addr", mem_araddr, 32'h1000);
    tick(); tick();
    ifu_arvalid = 1; lsu_arvalid = 1; lsu_araddr = 32'h2200;
    tick();
    chk("tie2_addr", mem_araddr, 32'h2200);
    tick(); tick(); tick(); tick(); tick();

    // LSU burst of four with gappy rvalid while IFU waits
    mem_rvalid = 0;
    lsu_arvalid = 1; lsu_araddr = 32'h3300; lsu_arlen = 3;
    tick();
    ifu_arvalid = 1; ifu_araddr = 32'h3000; ifu_arlen = 0;
    tick();
    beats = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      mem_rvalid = c[0];
      mem_rdata = $urandom;
      set_rlast();
      #1;
      if (lsu_rvalid && lsu_rready) beats++;
      chk("burst_ifu_rvalid", ifu_rvalid, 0);
      tick();
    end
    chk("burst_beats", beats, 4);
    mem_rvalid = 0;
    chk("burst_gap_arvalid", mem_arvalid, 0);
    tick();
    chk("burst_next_arvalid", mem_arvalid, 1);
    chk("burst_next_addr", mem_araddr, 32'h3000);
    tick();
    mem_rvalid = 1;
    tick();
    mem_rvalid = 0;

    // address channel stall keeps payload steady
    ifu_arvalid = 1; ifu_araddr = 32'h4000; ifu_arlen = 1; mem_arready = 0;
    tick();
    lsu_arvalid = 1; lsu_araddr = 32'h5000; lsu_arlen = 3;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_arvalid", mem_arvalid, 1);
      chk("stall_addr", mem_araddr, 32'h4000);
      chk("stall_lsu_arready", lsu_arready, 0);
      tick();
    end
    mem_arready = 1;
    tick();
    mem_rvalid = 1; mem_rresp = 2'b10;
    tick(); tick();
    mem_rresp = 2'b00;

    // reset during the second beat of an LSU burst
    tick(); tick();
    tick();
    set_rlast();
    #1;
    chk("rst_mid_before", lsu_rvalid, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_lsu_rvalid", lsu_rvalid, 0);
    chk("rst_mid_mem_rready", mem_rready, 0);
    chk("rst_mid_ifu_rvalid", ifu_rvalid, 0);
    chk("rst_mid_lsu_grants", lsu_grants, 0);
    model_reset();
    tick();
    reset = 1'b1;
    mem_rvalid = 0;
    ifu_arvalid = 1; ifu_araddr = 32'h6000; ifu_arlen = 0;
    tick();
    chk("post_rst_addr", mem_araddr, 32'h6000);
    tick();
    mem_rvalid = 1;
    tick();
    chk("post_rst_grants", ifu_grants, 1);

    // random traffic, long enough to saturate both counters
    for (int c = 0; c < 2500; c++) begin
      if (!ifu_arvalid && $urandom_range(0, 2) == 0) begin
        ifu_arvalid = 1; ifu_araddr = $urandom; ifu_arid = 4'($urandom);
        ifu_arlen = 8'($urandom_range(0, 3));
      end
      if (!lsu_arvalid && $urandom_range(0, 2) == 0) begin
        lsu_arvalid = 1; lsu_araddr = $urandom; lsu_arid = 4'($urandom);
        lsu_arlen = 8'($urandom_range(0, 3));
      end
      mem_arready = 1'($urandom_range(0, 1));
      mem_rvalid  = ($urandom_range(0, 2) != 0);
      mem_rdata   = $urandom;
      mem_rresp   = 2'($urandom);
      mem_rid     = 4'($urandom);
      ifu_rready  = ($urandom_range(0, 3) != 0);
      lsu_rready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk("sat_ifu_grants", ifu_grants, CNT_MAX);
    chk("sat_lsu_grants", lsu_grants, CNT_MAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
